// File: rtl/hvac_sequencer_if.sv
// Controller <-> sequencer bundle: raw requests and alarm in, protected enables and status out.
interface hvac_sequencer_if;
  logic        heat_req;
  logic        cool_req;
  logic        alarm;
  logic        heater;
  logic        cooler;
  logic [2:0]  status;
  logic [15:0] run_cnt;

  modport master (
    output heat_req, cool_req, alarm,
    input  heater, cooler, status, run_cnt
  );

  modport slave (
    input  heat_req, cool_req, alarm,
    output heater, cooler, status, run_cnt
  );
endinterface

// File: rtl/hvac_sequencer.sv
// Heater/cooler sequencer with minimum on-time, rest period, mutual exclusion and alarm lockout.
// Optional HVAC_RUNTIME_EN compiles in the saturating run-time counter behind run_cnt.
module hvac_sequencer #(
  parameter int unsigned MIN_ON  = 8,
  parameter int unsigned MIN_OFF = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic              Clk,
  input logic              Rst,
  hvac_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHeat = 3'd1,
    StCool = 3'd2,
    StRest = 3'd3,
    StLock = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MinOnLast  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MinOffLast = CNT_W'(MIN_OFF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    if (bus.alarm) begin
      state_d = StLock;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.heat_req)      state_d = StHeat;
          else if (bus.cool_req) state_d = StCool;
        end
        StHeat: if (!bus.heat_req && cnt_q >= MinOnLast) state_d = StRest;
        StCool: if (!bus.cool_req && cnt_q >= MinOnLast) state_d = StRest;
        StRest: if (cnt_q == MinOffLast) state_d = StIdle;
        StLock: state_d = StRest;
        default: state_d = StIdle;
      endcase
    end
  end

  // Phase counter restarts on every state change and saturates while a state is held.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Enables decode straight from the state register, so they are exclusive by construction.
  assign bus.heater = (state_q == StHeat);
  assign bus.cooler = (state_q == StCool);
  assign bus.status = state_q;

`ifdef HVAC_RUNTIME_EN
  logic [15:0] run_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      run_cnt_q <= '0;
    end else if ((state_q == StHeat || state_q == StCool) && run_cnt_q != 16'hFFFF) begin
      run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign bus.run_cnt = run_cnt_q;
`else
  assign bus.run_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hvac_sequencer.sv
// Bench for hvac_sequencer: fixed vector table, directed corner sequences and a randomized run
// checked against an abstract model (active actuator, run age, rest countdown, lock flag).
module tb_hvac_sequencer;

  localparam int unsigned MinOn  = 4;
  localparam int unsigned MinOff = 3;
`ifdef HVAC_RUNTIME_EN
  localparam bit RuntimeEn = 1'b1;
`else
  localparam bit RuntimeEn = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;

  hvac_sequencer_if bus ();

  hvac_sequencer #(
    .MIN_ON  (MinOn),
    .MIN_OFF (MinOff),
    .CNT_W   (8)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: which actuator runs (0 none, 1 heat, 2 cool), edges since it started,
  // remaining rest cycles, alarm lock flag and accumulated run time.
  int m_act, m_age, m_rest, m_run;
  bit m_lock;

  function automatic void model_step(bit r, bit h, bit c, bit a);
    if (r) begin
      m_act = 0; m_age = 0; m_rest = 0; m_lock = 1'b0; m_run = 0;
      return;
    end
    if (m_act != 0 && m_run < 65535) m_run++;
    if (a) begin
      m_act = 0; m_rest = 0; m_lock = 1'b1;
    end else if (m_lock) begin
      m_lock = 1'b0; m_rest = MinOff;
    end else if (m_rest > 0) begin
      m_rest--;
    end else if (m_act != 0) begin
      m_age++;
      if (!(m_act == 1 ? h : c) && m_age >= int'(MinOn)) begin
        m_act = 0; m_rest = MinOff;
      end
    end else if (h) begin
      m_act = 1; m_age = 0;
    end else if (c) begin
      m_act = 2; m_age = 0;
    end
  endfunction

  function automatic logic [20:0] model_outs();
    logic [2:0]  st;
    logic [15:0] rc;
    if (m_lock)          st = 3'd4;
    else if (m_rest > 0) st = 3'd3;
    else                 st = 3'(m_act);
    rc = RuntimeEn ? 16'(m_run) : 16'h0000;
    return {st == 3'd1, st == 3'd2, st, rc};
  endfunction

  function automatic logic [20:0] dut_outs();
    return {bus.heater, bus.cooler, bus.status, bus.run_cnt};
  endfunction

  task automatic check(string name, logic [20:0] got, logic [20:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got heater/cooler/status/run_cnt %h, want %h", name, got, want);
  endtask

  task automatic check_val(string name, int got, int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Drive inputs, advance one edge, update the model, then settle before sampling.
  task automatic cycle(bit r, bit h, bit c, bit a);
    Rst = r; bus.heat_req = h; bus.cool_req = c; bus.alarm = a;
    @(posedge Clk);
    model_step(r, h, c, a);
    #1;
  endtask

  task automatic cycle_chk(string name, bit r, bit h, bit c, bit a);
    cycle(r, h, c, a);
    check(name, dut_outs(), model_outs());
  endtask

  typedef struct packed {
    bit          rst;
    bit          heat;
    bit          cool;
    bit          alarm;
    bit          heater;
    bit          cooler;
    logic [2:0]  status;
    logic [15:0] run;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int cnt;
    bit h, c;

    // Basic heat pulse, cool run with alarm, alarm re-assert during rest, reset mid-cool.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd3};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd4};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd4};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd4};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'd4};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'd5};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'd6};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'd6};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'd6};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'd6};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'd6};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd6};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd6};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd6};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd6};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'd6};
    tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd0};

    Rst = 1'b1; bus.heat_req = 1'b0; bus.cool_req = 1'b0; bus.alarm = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_state", dut_outs(), 21'h0);

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].rst, tbl[i].heat, tbl[i].cool, tbl[i].alarm);
      check($sformatf("table_row_%0d", i), dut_outs(),
            {tbl[i].heater, tbl[i].cooler, tbl[i].status, RuntimeEn ? tbl[i].run : 16'h0});
    end

    // Long cool request: enable tracks the request beyond MIN_ON.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle_chk("long_cool_on", 1'b0, 1'b0, 1'b1, 1'b0);
      if (bus.cooler) cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle_chk("long_cool_off", 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.cooler) cnt++;
    end
    check_val("long_cool_len", cnt, 10);

    // Both requests from idle: heat wins, cool follows after the rest period.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle_chk("conflict_both", 1'b0, 1'b1, 1'b1, 1'b0);
      if (bus.cooler) cnt++;
    end
    check_val("conflict_cooler_off", cnt, 0);
    for (int i = 0; i < 8; i++) cycle_chk("conflict_cool", 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("conflict_ends_cool", int'(bus.status), 2);

    // Alarm at cycle 2 of heat with requests held through lock and rest.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle_chk("alarm_heat_start", 1'b0, 1'b1, 1'b1, 1'b0);
    cycle_chk("alarm_heat_run", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle_chk("alarm_lock", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle_chk("alarm_release", 1'b0, 1'b1, 1'b1, 1'b0);

    // 20-cycle heat run; run_cnt reads zero when the counter is not built.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle_chk("run20", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle_chk("run20_end", 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("run20_cnt", int'(bus.run_cnt), RuntimeEn ? 20 : 0);

`ifdef HVAC_RUNTIME_EN
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle_chk("sat_start", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 force dut.run_cnt_q = 16'hFFFD;
    #1 release dut.run_cnt_q;
    m_run = 16'hFFFD;
    for (int i = 0; i < 5; i++) cycle_chk("sat_run", 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sat_hold", int'(bus.run_cnt), 65535);
`endif

    // Randomized run with sticky request levels so long runs and rests occur.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    h = 1'b0;
    c = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 20) h = ~h;
      if ($urandom_range(0, 99) < 20) c = ~c;
      cycle_chk("random", $urandom_range(0, 199) == 0, h, c, $urandom_range(0, 99) < 4);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Sequencer between the home-automation controller and the climate actuators. It converts raw heat/cool requests into protected heater/cooler enables. It enforces a minimum on-time, a mandatory rest period between runs, and mutual exclusion of the two actuators. A fire-alarm lockout forces both actuators off immediately.

## Interface
- MIN_ON, default 8: minimum cycles an actuator stays enabled once started; legal range 1..2^CNT_W-1.
- MIN_OFF, default 4: cycles both actuators stay off after any run or lockout; legal range 1..2^CNT_W-1.
- CNT_W, default 8: width of the internal phase counter.
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- heat_req  in  1  heating requested by the controller (level).
- cool_req  in  1  cooling requested by the controller (level).
- alarm  in  1  fire alarm active (level); overrides everything.
- heater  out  1  heater enable.
- cooler  out  1  cooler enable.
- status  out  3  current state code.
- run_cnt  out  16  saturating count of cycles with heater or cooler enabled.

## Operation
- The state register holds one of five states: IDLE=0, HEAT=1, COOL=2, REST=3, LOCK=4.
- status equals the state code. heater=(state==HEAT). cooler=(state==COOL). Both are decoded from the state register, so they can never be high together.
- The phase counter cnt is CNT_W bits. It clears to 0 on every state change, increments each cycle the state is held, and saturates at all-ones.
- Transitions, evaluated at each rising edge, first match wins:
  - Rst=1: go to IDLE; cnt=0; run_cnt=0.
  - alarm=1: from any state go to LOCK. This includes mid-run before MIN_ON has elapsed.
  - IDLE: heat_req=1 goes to HEAT; otherwise cool_req=1 goes to COOL; otherwise stay. Heat wins when both requests are high.
  - HEAT: go to REST when heat_req=0 and cnt>=MIN_ON-1; otherwise stay. A cool_req arriving during HEAT has no effect until heat_req drops.
  - COOL: same rule, using cool_req.
  - REST: go to IDLE when cnt==MIN_OFF-1; otherwise stay. Requests are ignored during REST.
  - LOCK: go to REST when alarm=0. A full MIN_OFF rest always follows a lockout.
- run_cnt increments on every cycle where heater or cooler is high. It holds at 16'hFFFF once saturated.
- Unused state encodings 5..7 go to IDLE on the next edge with cnt=0.

## Timing
- All outputs are low after reset: heater=0, cooler=0, status=0, run_cnt=0.
- Start latency is 1 cycle. A request sampled high at edge N drives the enable high from edge N onward. There is no combinational path from inputs to outputs.
- An actuator run lasts max(MIN_ON, request-high duration in cycles, counted from entry) cycles. It ends at the first edge where the request is low and cnt>=MIN_ON-1.
- REST lasts exactly MIN_OFF cycles. The earliest restart is MIN_OFF+1 cycles after the enable falls, including the IDLE evaluation edge.
- Alarm latency is 1 cycle: an alarm sampled at edge N drops both enables from edge N.
- If alarm is released and reasserted during REST, the block returns to LOCK and the rest period restarts after the next release.
- Rst has priority over alarm.

## Configuration
- HVAC_RUNTIME_EN
  - Defined: the run_cnt register and incrementer are compiled in as described above.
  - Undefined: the port remains, tied to 16'h0000, and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Basic heat cycle, MIN_ON=4, MIN_OFF=3: pulse heat_req for 1 cycle -> heater high exactly 4 cycles, status 1→3 for 3 cycles→0; run_cnt=4 (macro defined).
- Long request: hold cool_req for 10 cycles -> cooler high for 10 cycles; then 3 cycles of REST; status sequence 2,3,0.
- Conflict and priority: assert heat_req and cool_req together from IDLE -> HEAT; cooler stays 0 throughout. When heat_req drops after MIN_ON, go to REST for 3 cycles, then COOL.
- Alarm mid-run: alarm at cycle 2 of HEAT -> heater 0 the next cycle, status=4. Hold alarm 5 cycles, then release -> 3 cycles REST -> IDLE. Requests held high during LOCK/REST start HEAT only after IDLE.
- Reset mid-operation: Rst for 1 cycle during COOL -> next cycle status=0, cooler=0, run_cnt=0. Requests are re-honoured the following cycle.
- Saturation and config: with macro undefined, a 20-cycle run keeps run_cnt=0. With macro defined, force run_cnt near 16'hFFFF -> it holds at 16'hFFFF.
